// File: rtl/wb_regfile_stage.sv
// Write-back stage: MEM/WB register, load extraction/extension, result select,
// multi-port register file and retire counter. Optional macro WB_RF_BYPASS_EN adds write-to-read forwarding.
module wb_regfile_stage #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 32,
  localparam int AW    = $clog2(REG_N)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_alu_result,
  input  logic [DATA_W-1:0]        in_mem_data,
  input  logic                     in_mem_to_reg,
  input  logic [2:0]               in_load_type,
  input  logic [1:0]               in_byte_off,
  input  logic                     in_reg_write,
  input  logic [AW-1:0]            in_rd,
  input  logic [NUM_RD*AW-1:0]     raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic                     wb_valid,
  output logic                     wb_we,
  output logic [AW-1:0]            wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [CNT_W-1:0]         retire_count
);

  logic              r_valid;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [AW-1:0]     r_rd;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_mem;
  logic [2:0]        r_load_type;
  logic [1:0]        r_byte_off;
  logic [DATA_W-1:0] r_regs [REG_N];
  logic [CNT_W-1:0]  r_retire;

  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_data;
  logic              w_we;
  logic              w_commit;

  // MEM/WB register: flush beats stall; a bubble only clears valid/reg_write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_rd         <= '0;
      r_alu        <= '0;
      r_mem        <= '0;
      r_load_type  <= '0;
      r_byte_off   <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (!stall) begin
      r_valid      <= in_valid;
      r_reg_write  <= in_reg_write;
      r_mem_to_reg <= in_mem_to_reg;
      r_rd         <= in_rd;
      r_alu        <= in_alu_result;
      r_mem        <= in_mem_data;
      r_load_type  <= in_load_type;
      r_byte_off   <= in_byte_off;
    end
  end

  // Little-endian lane select; halfword ignores the low offset bit.
  always_comb begin
    w_byte = r_mem[{r_byte_off, 3'b000} +: 8];
    w_half = r_mem[{r_byte_off[1], 4'b0000} +: 16];
    w_data = r_alu;
    if (r_mem_to_reg) begin
      case (r_load_type)
        3'd1:    w_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
        3'd2:    w_data = {{(DATA_W-8){1'b0}}, w_byte};
        3'd3:    w_data = {{(DATA_W-16){w_half[15]}}, w_half};
        3'd4:    w_data = {{(DATA_W-16){1'b0}}, w_half};
        default: w_data = r_mem;
      endcase
    end
  end

  assign w_we     = r_valid & r_reg_write & (r_rd != '0);
  assign w_commit = w_we & ~stall;

  // Commit is not cancelled by a same-edge flush; only stall defers it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
    end else if (w_commit) begin
      r_regs[r_rd] <= w_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_retire <= '0;
    end else if (r_valid && !stall && !flush) begin
      r_retire <= r_retire + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]     w_ra;
    logic [DATA_W-1:0] w_rd;
    assign w_ra = raddr[k*AW +: AW];
    always_comb begin
      w_rd = r_regs[w_ra];
`ifdef WB_RF_BYPASS_EN
      if (w_we && (w_ra == r_rd)) w_rd = w_data;
`endif
      if (w_ra == '0) w_rd = '0;
    end
    assign rdata[k*DATA_W +: DATA_W] = w_rd;
  end

  assign wb_valid     = r_valid;
  assign wb_we        = w_we;
  assign wb_addr      = r_rd;
  assign wb_data      = w_data;
  assign retire_count = r_retire;

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Bench for wb_regfile_stage: directed scenarios plus random traffic against an
// array/arithmetic reference model; CNT_W=4 so the retire counter wraps.
module tb_wb_regfile_stage;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int NR = 2;
  localparam int CW = 4;
  localparam int AW = 5;

  logic             clk;
  logic             reset;
  logic             stall;
  logic             flush;
  logic             in_valid;
  logic [DW-1:0]    in_alu_result;
  logic [DW-1:0]    in_mem_data;
  logic             in_mem_to_reg;
  logic [2:0]       in_load_type;
  logic [1:0]       in_byte_off;
  logic             in_reg_write;
  logic [AW-1:0]    in_rd;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic             wb_valid;
  logic             wb_we;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic [CW-1:0]    retire_count;

  wb_regfile_stage #(.DATA_W(DW), .REG_N(RN), .NUM_RD(NR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_mem_to_reg(in_mem_to_reg),
    .in_load_type(in_load_type), .in_byte_off(in_byte_off), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .raddr(raddr), .rdata(rdata), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_addr(wb_addr), .wb_data(wb_data), .retire_count(retire_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [DW-1:0] m_regs [RN];
  bit            m_v;
  bit            m_rw;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  int            m_cnt;

  logic [DW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_wdata(input logic [DW-1:0] alu, input logic [DW-1:0] mem,
                                              input bit m2r, input int lt, input int off);
    int unsigned b;
    int unsigned h;
    if (!m2r) return alu;
    b = (mem >> (8 * off)) & 32'hFF;
    h = (mem >> (16 * (off / 2))) & 32'hFFFF;
    case (lt)
      1:       return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      2:       return b;
      3:       return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4:       return h;
      default: return mem;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < RN; i++) m_regs[i] = '0;
    m_v = 0; m_rw = 0; m_rd = '0; m_data = '0; m_cnt = 0;
  endtask

  task automatic model_edge();
    if (m_v && m_rw && m_rd != 0 && !stall) m_regs[m_rd] = m_data;
    if (m_v && !stall && !flush) m_cnt = (m_cnt + 1) % 16;
    if (flush) begin
      m_v = 0; m_rw = 0;
    end else if (!stall) begin
      m_v    = in_valid;
      m_rw   = in_reg_write;
      m_rd   = in_rd;
      m_data = ref_wdata(in_alu_result, in_mem_data, in_mem_to_reg, in_load_type, in_byte_off);
    end
  endtask

  // compare all visible outputs with the model, inputs already applied
  task automatic settle();
    bit m_we;
    logic [AW-1:0] ra;
    #1;
    m_we = m_v && m_rw && (m_rd != 0);
    check("wb_valid", DW'(wb_valid), DW'(m_v));
    check("wb_we", DW'(wb_we), DW'(m_we));
    if (m_v) begin
      check("wb_addr", DW'(wb_addr), DW'(m_rd));
      check("wb_data", wb_data, m_data);
    end
    check("retire_count", DW'(retire_count), DW'(m_cnt));
    for (int k = 0; k < NR; k++) begin
      ra = raddr[k*AW +: AW];
      if (ra == 0) exp_q.push_back('0);
`ifdef WB_RF_BYPASS_EN
      else if (m_we && ra == m_rd) exp_q.push_back(m_data);
`endif
      else exp_q.push_back(m_regs[ra]);
    end
    for (int k = 0; k < NR; k++) check("rdata", rdata[k*DW +: DW], exp_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  // driver tasks
  task automatic set_in(input bit rw, input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                        input logic [DW-1:0] mem, input bit m2r, input logic [2:0] lt,
                        input logic [1:0] off);
    stall = 0; flush = 0; in_valid = 1;
    in_reg_write = rw; in_rd = rd; in_alu_result = alu; in_mem_data = mem;
    in_mem_to_reg = m2r; in_load_type = lt; in_byte_off = off;
  endtask

  task automatic idle();
    stall = 0; flush = 0; in_valid = 0; in_reg_write = 0;
  endtask

  task automatic rand_in();
    stall         = ($urandom_range(0, 99) < 20);
    flush         = ($urandom_range(0, 99) < 10);
    in_valid      = ($urandom_range(0, 99) < 80);
    in_reg_write  = ($urandom_range(0, 99) < 70);
    in_rd         = AW'($urandom_range(0, RN - 1));
    in_alu_result = $urandom;
    in_mem_data   = $urandom;
    in_mem_to_reg = $urandom_range(0, 1);
    in_load_type  = 3'($urandom_range(0, 7));
    in_byte_off   = 2'($urandom_range(0, 3));
    raddr         = NR*AW'($urandom);
  endtask

  logic [DW-1:0] ld_exp [5];
  logic [2:0]    ld_lt  [5];
  logic [1:0]    ld_off [5];

  initial begin
    reset = 1; raddr = '0; in_alu_result = '0; in_mem_data = '0; in_mem_to_reg = 0;
    in_load_type = '0; in_byte_off = '0; in_rd = '0;
    idle();
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 0;

    // reset state
    raddr = {5'd3, 5'd5};
    settle();
    check("rst_wb_addr", DW'(wb_addr), 0);
    check("rst_wb_data", wb_data, 0);
    tick();

    // simple ALU write and readback
    set_in(1, 5, 32'h1234_5678, 32'h0, 0, 0, 0);
    step();
    idle();
    settle();
    check("t2_wb_we", DW'(wb_we), 1);
    tick();
    raddr = {5'd0, 5'd5};
    settle();
    check("t2_rdata0", rdata[DW-1:0], 32'h1234_5678);
    check("t2_retire", DW'(retire_count), 1);
    tick();

    // write to reg 0 is suppressed but still retires
    set_in(1, 0, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
    step();
    idle();
    raddr = {5'd0, 5'd0};
    settle();
    check("t4_wb_we", DW'(wb_we), 0);
    check("t4_rdata0", rdata[DW-1:0], 0);
    tick();
    settle();
    check("t4_retire", DW'(retire_count), 2);
    tick();

    // load extraction / extension
    ld_lt[0] = 1; ld_off[0] = 2; ld_exp[0] = 32'hFFFF_FFF1;
    ld_lt[1] = 2; ld_off[1] = 3; ld_exp[1] = 32'h0000_0080;
    ld_lt[2] = 3; ld_off[2] = 1; ld_exp[2] = 32'h0000_7F22;
    ld_lt[3] = 4; ld_off[3] = 2; ld_exp[3] = 32'h0000_80F1;
    ld_lt[4] = 0; ld_off[4] = 0; ld_exp[4] = 32'h80F1_7F22;
    for (int i = 0; i < 5; i++) begin
      set_in(1, AW'(10 + i), 32'h0, 32'h80F1_7F22, 1, ld_lt[i], ld_off[i]);
      step();
      idle();
      settle();
      check($sformatf("t3_load%0d", i), wb_data, ld_exp[i]);
      tick();
    end
    // retire count is now 7

    // stall holds the entry: no commit, no retire
    set_in(1, 7, 32'h0000_0077, 32'h0, 0, 0, 0);
    raddr = {5'd0, 5'd7};
    step();
    for (int i = 0; i < 3; i++) begin
      set_in(1, 12, $urandom, $urandom, 0, 0, 0);
      stall = 1;
      settle();
`ifdef WB_RF_BYPASS_EN
      check("t5_stall_rd", rdata[DW-1:0], 32'h0000_0077);
`else
      check("t5_stall_rd", rdata[DW-1:0], 0);
`endif
      check("t5_stall_cnt", DW'(retire_count), 7);
      tick();
    end
    idle();
    step();
    settle();
    check("t5_commit", rdata[DW-1:0], 32'h0000_0077);
    check("t5_cnt", DW'(retire_count), 8);
    tick();
    // stall and flush together load a bubble without committing
    set_in(1, 8, 32'h0000_0088, 32'h0, 0, 0, 0);
    raddr = {5'd0, 5'd8};
    step();
    set_in(1, 13, 32'h1313_1313, 32'h0, 0, 0, 0);
    stall = 1; flush = 1;
    step();
    idle();
    settle();
    check("t5_bubble", DW'(wb_valid), 0);
    check("t5_no_commit", rdata[DW-1:0], 0);
    check("t5_flush_cnt", DW'(retire_count), 8);
    tick();

    // same-cycle read of the address being committed
    set_in(1, 9, 32'hA5A5_A5A5, 32'h0, 0, 0, 0);
    step();
    idle();
    raddr = {5'd9, 5'd0};
    settle();
`ifdef WB_RF_BYPASS_EN
    check("t6_same_cycle", rdata[DW +: DW], 32'hA5A5_A5A5);
`else
    check("t6_same_cycle", rdata[DW +: DW], 0);
`endif
    tick();
    settle();
    check("t6_next_cycle", rdata[DW +: DW], 32'hA5A5_A5A5);
    tick();
    // count is 9; sixteen more retires wrap back to 9
    for (int i = 0; i < 16; i++) begin
      set_in(0, 0, $urandom, 32'h0, 0, 0, 0);
      step();
    end
    idle();
    step();
    settle();
    check("t6_wrap", DW'(retire_count), 9);
    tick();

    // random traffic with an asynchronous reset mid-run
    for (int c = 0; c < 400; c++) begin
      rand_in();
      if (c == 200) begin
        raddr = {5'd9, 5'd5};
        settle();
        #2 reset = 1;
        #1;
        check("rst_rdata0", rdata[DW-1:0], 0);
        check("rst_rdata1", rdata[DW +: DW], 0);
        check("rst_wb_valid", DW'(wb_valid), 0);
        check("rst_retire", DW'(retire_count), 0);
        model_reset();
        @(negedge clk);
        reset = 0;
      end else begin
        step();
      end
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
